// File: rtl/sweep_ctrl.sv
// Sweep sequencer in front of the LED bar decoder: latches N1/N2, runs IDLE/RUN/WAIT/DONE, steps pos_o per prescaled tick.
// Optional macro SWEEP_BOUNCE_EN: sweep returns N2->N1 before completing; otherwise direction_o stays 0.
module sweep_ctrl #(
    parameter int unsigned PRESC_DIV = 16,
    parameter int unsigned PRESC_W   = 16
) (
    input  logic       clc_i,
    input  logic       rst_i,
    input  logic [7:0] N1_in_i,
    input  logic [7:0] N2_in_i,
    input  logic       load_i,
    input  logic       start_i,
    input  logic       pause_i,
    input  logic       stop_i,
    output logic [7:0] N1_data_o,
    output logic [7:0] N2_data_o,
    output logic       led_en_o,
    output logic       led_wait_o,
    output logic       direction_o,
    output logic [7:0] pos_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESC_DIV - 1);

    state_t             state_q, state_d;
    logic [7:0]         n1_q, n1_d;
    logic [7:0]         n2_q, n2_d;
    logic               valid_q, valid_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [7:0]         pos_q, pos_d;
    logic               dir_q, dir_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               led_en_q, led_en_d;
    logic               led_wait_q, led_wait_d;
    logic               busy_q, busy_d;
    logic               tick_s;

    // Next-state, bound latch and position stepping; outputs follow the next state so they are registered.
    always_comb begin
        state_d = state_q;
        n1_d    = n1_q;
        n2_d    = n2_q;
        valid_d = valid_q;
        presc_d = presc_q;
        pos_d   = pos_q;
        dir_d   = dir_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        tick_s  = (presc_q == PRESC_LAST);

        case (state_q)
            IDLE: begin
                if (load_i) begin
                    if (N1_in_i < N2_in_i) begin
                        n1_d    = N1_in_i;
                        n2_d    = N2_in_i;
                        valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    err_d = 1'b0;
                end
                // Start uses the bounds that were valid before any same-cycle load.
                if (start_i && !stop_i && valid_q) begin
                    state_d = RUN;
                    pos_d   = n1_q;
                    presc_d = '0;
                    dir_d   = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (stop_i) begin
                    state_d = IDLE;
                    pos_d   = 8'd0;
                    presc_d = '0;
                    dir_d   = 1'b0;
                end else if (pause_i) begin
                    state_d = WAIT;
                end else if (tick_s) begin
                    presc_d = '0;
`ifdef SWEEP_BOUNCE_EN
                    if (!dir_q) begin
                        if (pos_q == n2_q) begin
                            dir_d = 1'b1;
                        end else begin
                            pos_d = pos_q + 8'd1;
                        end
                    end else begin
                        if (pos_q == n1_q) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            pos_d = pos_q - 8'd1;
                        end
                    end
`else
                    if (pos_q == n2_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        pos_d = pos_q + 8'd1;
                    end
`endif
                end else begin
                    presc_d = presc_q + PRESC_W'(1);
                end
            end
            WAIT: begin
                if (stop_i) begin
                    state_d = IDLE;
                    pos_d   = 8'd0;
                    presc_d = '0;
                    dir_d   = 1'b0;
                end else if (!pause_i) begin
                    state_d = RUN;
                end else begin
                    state_d = WAIT;
                end
            end
            DONE: begin
                if (stop_i) begin
                    state_d = IDLE;
                    pos_d   = 8'd0;
                    presc_d = '0;
                    dir_d   = 1'b0;
                end else if (start_i) begin
                    state_d = RUN;
                    pos_d   = n1_q;
                    presc_d = '0;
                    dir_d   = 1'b0;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
                pos_d   = 8'd0;
                presc_d = '0;
                dir_d   = 1'b0;
            end
        endcase

        led_en_d   = (state_d == RUN);
        led_wait_d = (state_d == WAIT) || (state_d == DONE);
        busy_d     = (state_d == RUN) || (state_d == WAIT);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clc_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            n1_q       <= 8'd0;
            n2_q       <= 8'd0;
            valid_q    <= 1'b0;
            presc_q    <= '0;
            pos_q      <= 8'd0;
            dir_q      <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            led_en_q   <= 1'b0;
            led_wait_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            n1_q       <= n1_d;
            n2_q       <= n2_d;
            valid_q    <= valid_d;
            presc_q    <= presc_d;
            pos_q      <= pos_d;
            dir_q      <= dir_d;
            done_q     <= done_d;
            err_q      <= err_d;
            led_en_q   <= led_en_d;
            led_wait_q <= led_wait_d;
            busy_q     <= busy_d;
        end
    end

    assign N1_data_o   = n1_q;
    assign N2_data_o   = n2_q;
    assign led_en_o    = led_en_q;
    assign led_wait_o  = led_wait_q;
    assign direction_o = dir_q;
    assign pos_o       = pos_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

endmodule
